// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator fed by a valid/ready command
// port, returning one response per command with a programmable ack timeout.
module wb_cmd_master #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_dat,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,

    output logic        busy,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam bit               TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_dat_q;
    logic              cyc_q;
    logic              stb_q;
    logic              we_q;
    logic [31:0]       adr_q;
    logic [3:0]        sel_q;
    logic [31:0]       dat_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              timeout_hit;

    // Saturating count keeps a disabled timeout from ever wrapping into a match.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        we_q        <= cmd_we;
                        adr_q       <= cmd_adr;
                        sel_q       <= cmd_sel;
                        dat_q       <= cmd_dat;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        cnt_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (wb_ack_i) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_dat_q   <= we_q ? 32'h0 : wb_dat_i;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_dat_q   <= '0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    cyc_q       <= 1'b0;
                    stb_q       <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_dat   = rsp_dat_q;
    assign busy      = (state_q != IDLE);
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_sel_o  = sel_q;
    assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: random commands against a memory slave with per-
// transaction ack latency; a scoreboard compares responses to a reference model.
module tb_wb_cmd_master;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        busy;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT(T), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .busy(busy),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] rdat;
        logic        err;
        int          len;
        int          acks;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] ref_mem [64];
    logic [31:0] slv_mem [64];
    int          cur_lat = 1;
    int          hold_next = 0;
    bit          mon_en = 0;
    bit          aborting = 0;

    function automatic void check(string name, logic [71:0] act, logic [71:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference: slave at addresses < 0x100 acks in stb cycle lat+1 and commits
    // a write when it sees stb at cycle lat; the master gives up after T cycles.
    function automatic exp_t predict(logic we, logic [31:0] adr, logic [3:0] sel,
                                     logic [31:0] dat, int lat);
        exp_t e;
        bit   mapped = (adr[31:8] == 24'h0);
        int   idx = int'(adr[7:2]);
        e.we = we; e.adr = adr; e.sel = sel; e.dat = dat;
        e.rdat = 32'h0; e.err = 1'b1; e.len = T; e.acks = 0;
        if (mapped && (lat + 1 <= T)) begin
            e.err = 1'b0; e.len = lat + 1; e.acks = 1;
            if (!we) e.rdat = ref_mem[idx];
        end
        if (mapped && we && (lat <= T)) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
        end
        return e;
    endfunction

    task automatic send(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input int lat, input int hold);
        int waited = 0;
        bit ok = 0;
        cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat; cmd_valid = 1'b1;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (cmd_ready) ok = 1; else waited++;
        end
        check("cmd_accept", ok, 1);
        @(posedge clk); #1;
        if (ok) begin
            cur_lat = lat;
            hold_next = hold;
            exp_q.push_back(predict(we, adr, sel, dat, lat));
        end
        cmd_valid = 1'b0;
    endtask

    // Wishbone slave: registered ack after cur_lat stb cycles, plus stray acks
    // while a response is pending, which the master must ignore.
    initial begin
        int          w;
        bit          own;
        logic        n_ack;
        logic [31:0] n_dat;
        logic [5:0]  idx;
        w = 0; own = 0;
        for (int i = 0; i < 64; i++) slv_mem[i] = 32'h0;
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            n_ack = 1'b0; n_dat = $urandom; idx = wb_adr_o[7:2];
            if (wb_cyc_o && wb_stb_o && !own && wb_adr_o[31:8] == 24'h0) begin
                if (w == cur_lat - 1) begin
                    n_ack = 1'b1; w = 0;
                    if (wb_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (wb_sel_o[b]) slv_mem[idx][8*b +: 8] = wb_dat_o[8*b +: 8];
                    end else begin
                        n_dat = slv_mem[idx];
                    end
                end else begin
                    w++;
                end
            end else if (!(wb_cyc_o && wb_stb_o)) begin
                w = 0;
            end
            own = n_ack;
            if (rsp_valid && !n_ack && $urandom_range(0, 3) == 0) n_ack = 1'b1;
            @(posedge clk); #1;
            wb_ack_i = n_ack; wb_dat_i = n_dat;
        end
    end

    // Response consumer: optional forced stall at the start of a response.
    initial begin
        int left;
        bit pv;
        left = 0; pv = 0; rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rsp_valid && !pv) left = hold_next;
            pv = rsp_valid;
            if (left > 0) begin
                rsp_ready = 1'b0; left--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int          stb_cnt, ack_cnt;
        bit          prev_rv, prev_rr, prev_err;
        logic [31:0] prev_dat;
        stb_cnt = 0; ack_cnt = 0; prev_rv = 0; prev_rr = 0; prev_err = 0; prev_dat = 0;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && !aborting) begin
                check("ready_vs_busy", cmd_ready, !busy);
                check("cyc_vs_stb", wb_cyc_o, wb_stb_o);
                if (wb_stb_o) begin
                    check("stb_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0)
                        check("bus_fields", {wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o},
                              {exp_q[0].we, exp_q[0].adr, exp_q[0].sel, exp_q[0].dat});
                    stb_cnt++;
                    if (wb_ack_i) ack_cnt++;
                end
                if (rsp_valid) begin
                    check("ready_in_resp", cmd_ready, 0);
                    check("rsp_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        if (!prev_rv) begin
                            check("stb_len", stb_cnt, exp_q[0].len);
                            check("ack_count", ack_cnt, exp_q[0].acks);
                            stb_cnt = 0; ack_cnt = 0;
                        end else if (!prev_rr) begin
                            check("rsp_hold", {rsp_err, rsp_dat}, {prev_err, prev_dat});
                        end
                        if (rsp_ready) begin
                            check("rsp_dat", rsp_dat, exp_q[0].rdat);
                            check("rsp_err", rsp_err, exp_q[0].err);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                prev_rv = rsp_valid; prev_rr = rsp_ready;
                prev_err = rsp_err; prev_dat = rsp_dat;
            end else begin
                prev_rv = 0; stb_cnt = 0; ack_cnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [31:0] adr;
        int          waited;
        bit          ok;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
        cmd_adr = 32'h0; cmd_sel = 4'h0; cmd_dat = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_dat}, 0);
        check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o}, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0; mon_en = 1;

        send(1'b1, 32'h04, 4'hF, 32'h0000_00FF, 1, 0);   // write, one-cycle ack
        send(1'b0, 32'h04, 4'hF, 32'h0, 1, 0);           // read-back
        send(1'b0, 32'h0001_0000, 4'hF, 32'h0, 1, 0);    // unmapped: timeout
        send(1'b0, 32'h04, 4'hF, 32'h0, 2, 5);           // response stalled 5 cycles
        send(1'b0, 32'h04, 4'hF, 32'h0, T - 1, 0);       // ack on last stb cycle wins
        send(1'b1, 32'h08, 4'h3, 32'hA5A5_1234, T, 0);   // late ack after timeout
        send(1'b0, 32'h08, 4'hF, 32'h0, 1, 0);
        for (int n = 0; n < 200; n++) begin
            we  = 1'($urandom_range(0, 1));
            adr = ($urandom_range(0, 9) < 8) ? {24'h0, 6'($urandom_range(0, 63)), 2'b00}
                                             : ($urandom | 32'h100);
            send(we, adr, 4'($urandom), $urandom, $urandom_range(1, T + 2),
                 ($urandom_range(0, 9) == 0) ? 5 : 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin @(posedge clk); #1; waited++; end
        check("drain", exp_q.size(), 0);

        // Abort a transaction with reset while the strobe is up.
        cmd_we = 1'b0; cmd_adr = 32'h0002_0000; cmd_sel = 4'hF; cmd_valid = 1'b1;
        ok = 0; waited = 0;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (cmd_ready) ok = 1; else waited++;
        end
        check("abort_accept", ok, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; aborting = 1;
        @(negedge clk);
        check("abort_stb_up", wb_stb_o, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_bus", {wb_cyc_o, wb_stb_o}, 0);
        check("abort_rsp", rsp_valid, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        aborting = 0;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
